note_highway: RTL and testbench
===============================

# note_highway

Chart-driven note scroller that produces the game-side inputs the guitar-hero processor consumes. It reads a song chart from a synchronous chart ROM, scrolls notes down four lanes one row per game step, and pulses `gameclk` on each step. It drives `intersections` with the hit-row contents. It accepts per-lane `clear` strobes when a hit is scored, and exposes the full lane grid for the display path.

## Interface
- `TICK_DIV`, default 1000000: clock cycles per game step; must be ≥ 3.
- `LANE_DEPTH`, default 16: rows per lane; row 0 is the hit row and row `LANE_DEPTH-1` is the entry row.
- `CHART_ADDR_W`, default 10: chart ROM address width.
- `clock` input, 1 bit: the block's only clock; all state updates on its rising edge.
- `reset` input, 1 bit: asynchronous, active-low; asserting it (low) clears all state immediately.
- `enable` input, 1 bit: run (1) or pause (0).
- `chart_addr` output, `CHART_ADDR_W` bits: chart ROM address; registered.
- `chart_data` input, 5 bits: `{end_flag, lane[3:0]}`; valid one cycle after `chart_addr` is presented.
- `clear` input, 4 bits: per-lane strobe that removes the note in row 0.
- `gameclk` output, 1 bit: one-cycle pulse per game step.
- `intersections` output, 4 bits: row 0 of lanes 3..0.
- `grid` output, 4*`LANE_DEPTH` bits: bit `[4*r+i]` is lane `i`, row `r`.
- `done` output, 1 bit: the chart has ended and the grid is empty.

## Operation
- **Reset values:** `chart_addr`=0, `gameclk`=0, `intersections`=0, `grid`=0, `done`=0, tick counter=0, ended flag=0, state=COUNT.
- **Tick counter:** counts 0..`TICK_DIV`-1 and wraps. It advances only when `enable`=1 and state≠DONE. It keeps counting through FETCH and LOAD, so the step period is exactly `TICK_DIV` enabled cycles.
- **COUNT:** when counter==`TICK_DIV`-1 and `enable`=1, go to FETCH.
- **FETCH:** `chart_addr` is held stable while the ROM samples it. Go to LOAD unconditionally, regardless of `enable`.
- **LOAD:** one shift step.
  - Row r takes row r+1 for r < `LANE_DEPTH`-1.
  - The entry row takes `chart_data[3:0]`, or 0 if the ended flag is already set or `chart_data[4]`=1.
  - If `chart_data[4]`=1, set the ended flag.
  - If the ended flag is not set and `chart_data[4]`=0, increment `chart_addr`.
  - If `chart_addr` is all ones, treat the step as end-of-chart: set the ended flag and do not wrap.
  - Pulse `gameclk`.
  - Next state is DONE if the ended flag is set (or being set) and the post-shift grid is all zero; otherwise COUNT.
- **DONE:** `done`=1 and the grid stays 0. No further `gameclk` pulses occur. Only reset exits DONE.
- **clear:** in any cycle without a LOAD update, `clear[i]`=1 zeroes row 0, lane i. Clearing an empty cell has no effect.
- **clear during LOAD:** `clear` is ignored when it coincides with the LOAD update. Row 0 is replaced by row 1, so the old row-0 note leaves the grid anyway.
- **Missed notes:** a note shifted out of row 0 is discarded. Miss accounting belongs to the processor.

## Timing
- `grid`, `intersections` and `gameclk` all update on the rising edge that ends the LOAD cycle.
- `gameclk` is high for exactly one cycle, concurrent with the first cycle of the new grid.
- With `enable` held at 1, `gameclk` pulses are spaced exactly `TICK_DIV` cycles apart.
- **First pulse after reset release:** the counter reaches `TICK_DIV`-1 after `TICK_DIV`-1 enabled cycles, then FETCH and LOAD follow. The first `gameclk` therefore goes high `TICK_DIV`+1 cycles after the first enabled edge.
- A chart note reaches row 0, `LANE_DEPTH`-1 steps after entering the grid.
- **Pause:** while `enable`=0 the counter holds. A FETCH/LOAD already in flight completes.
- **Reset mid-step:** asserting `reset` during FETCH or LOAD aborts the step immediately. All outputs return to their reset values asynchronously.

## Test plan
Test parameters: `TICK_DIV`=4, `LANE_DEPTH`=4. Chart contents: addr0=5'b00001, addr1=5'b00010, addr2=5'b10000.

- **Reset:** hold `reset`=0 with random inputs -> all outputs 0 and `chart_addr`=0. Release with `enable`=1 -> first `gameclk` 5 cycles later with `grid`[15:12]=4'b0001, then pulses every 4 cycles.
- **Scroll:** after 4 steps -> `intersections`=4'b0001. After 5 steps -> `intersections`=4'b0010. After 6 steps -> `intersections`=0.
- **Clear:** `clear`=4'b0001 in a non-LOAD cycle while `intersections`=4'b0001 -> `intersections`=0 next cycle, other rows unchanged. The same `clear` in the LOAD cycle -> ignored, and row 0 takes the shifted row 1.
- **End of chart:** `chart_addr` stops at 2. Zeros are loaded thereafter. `done`=1 with `grid`=0 after the last note exits row 0, and no `gameclk` pulses follow.
- **Pause:** `enable`=0 for 10 cycles mid-COUNT -> no `gameclk` and the counter frozen. On resume, the next pulse comes at the remaining count + 2.
- **Reset during LOAD:** drive `reset` low in a LOAD cycle -> `grid`, `gameclk` and `chart_addr` are 0 before the next clock edge.

Source files
------------

// File: rtl/note_highway.sv
// note_highway
//   Chart-driven note scroller. Reads a song chart from a synchronous ROM,
//   scrolls notes down four lanes one row per game step, pulses gameclk once
//   per step and presents the hit row on intersections.
//
// Ports
//   clock          : clock, all state updates on the rising edge
//   reset          : asynchronous, active-low reset
//   enable         : 1 = run, 0 = pause the step counter
//   chart_addr     : registered chart ROM address
//   chart_data     : {end_flag, lane[3:0]}, valid one cycle after chart_addr
//   clear          : per-lane strobe removing the note in row 0
//   gameclk        : one-cycle pulse per game step
//   intersections  : row 0 of lanes 3..0
//   grid           : full lane grid, bit [4*r+i] is lane i, row r
//   done           : chart has ended and the grid is empty
module note_highway #(
  parameter int unsigned TICK_DIV     = 1000000,
  parameter int unsigned LANE_DEPTH   = 16,
  parameter int unsigned CHART_ADDR_W = 10
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  output logic [CHART_ADDR_W-1:0] chart_addr,
  input  logic [4:0]              chart_data,
  input  logic [3:0]              clear,
  output logic                    gameclk,
  output logic [3:0]              intersections,
  output logic [4*LANE_DEPTH-1:0] grid,
  output logic                    done
);

  localparam int unsigned CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_COUNT,
    S_FETCH,
    S_LOAD,
    S_DONE
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [CNT_W-1:0]        tick_cnt;
  logic                    ended;

  logic                    tick_adv;
  logic                    tick_wrap;
  logic                    load;
  logic                    end_mark;
  logic                    addr_full;
  logic                    end_now;
  logic                    addr_inc;
  logic [3:0]              entry;
  logic [4*LANE_DEPTH-1:0] shifted;

  always_comb begin
    tick_adv  = enable && (state != S_DONE);
    tick_wrap = (tick_cnt == TICK_LAST);
    load      = (state == S_LOAD);
    end_mark  = chart_data[4];
    addr_full = &chart_addr;
    // The last ROM address still delivers its note, but the chart is
    // considered finished there because the address cannot advance further.
    end_now   = ended || end_mark || addr_full;
    addr_inc  = !ended && !end_mark && !addr_full;
    entry     = (ended || end_mark) ? 4'b0000 : chart_data[3:0];
    shifted   = {entry, grid[4*LANE_DEPTH-1:4]};
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_COUNT: if (enable && tick_wrap) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = (end_now && (shifted == '0)) ? S_DONE : S_COUNT;
      S_DONE:  state_next = S_DONE;
      default: state_next = S_COUNT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_COUNT;
    end else begin
      state <= state_next;
    end
  end

  // The counter keeps running through FETCH and LOAD so the step period is
  // exactly TICK_DIV enabled cycles regardless of the fetch latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick_cnt <= '0;
    end else if (tick_adv) begin
      tick_cnt <= tick_wrap ? '0 : tick_cnt + CNT_W'(1);
    end
  end

  // clear is not applied in the LOAD cycle: row 0 is overwritten by row 1,
  // so the old hit-row note leaves the grid in any case.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grid       <= '0;
      ended      <= 1'b0;
      chart_addr <= '0;
      gameclk    <= 1'b0;
    end else begin
      gameclk <= load;
      if (load) begin
        grid  <= shifted;
        ended <= end_now;
        if (addr_inc) begin
          chart_addr <= chart_addr + CHART_ADDR_W'(1);
        end
      end else begin
        grid[3:0] <= grid[3:0] & ~clear;
      end
    end
  end

  assign intersections = grid[3:0];
  assign done          = (state == S_DONE);

endmodule

// File: tb/tb_note_highway.sv
module tb_note_highway;

  localparam int unsigned TD = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = 10;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [AW-1:0] chart_addr;
  logic [4:0]    chart_data;
  logic [3:0]    clear;
  logic          gameclk;
  logic [3:0]    intersections;
  logic [4*D-1:0] grid;
  logic          done;

  note_highway #(
    .TICK_DIV    (TD),
    .LANE_DEPTH  (D),
    .CHART_ADDR_W(AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .chart_addr   (chart_addr),
    .chart_data   (chart_data),
    .clear        (clear),
    .gameclk      (gameclk),
    .intersections(intersections),
    .grid         (grid),
    .done         (done)
  );

  always #5 clock = ~clock;

  // Synchronous chart ROM: data appears one cycle after the address.
  logic [4:0] rom [0:(1<<AW)-1];
  always @(posedge clock) chart_data <= rom[chart_addr];

  int checks   = 0;
  int failures = 0;

  // Reference model: the lane grid is a queue of rows (front = hit row).
  // A step is scheduled two edges after every TD-th enabled edge.
  logic [3:0] mq[$];
  int         m_ptr;
  bit         m_ended;
  bit         m_done;
  int         m_en_edges;
  int         m_sched;
  bit         m_pulse;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int unsigned r = 0; r < D; r++) mq.push_back(4'b0000);
    m_ptr = 0; m_ended = 0; m_done = 0;
    m_en_edges = 0; m_sched = 0; m_pulse = 0;
  endtask

  function automatic bit model_empty();
    bit e = 1;
    foreach (mq[r]) if (mq[r] != 4'b0000) e = 0;
    return e;
  endfunction

  function automatic logic [4*D-1:0] model_grid();
    logic [4*D-1:0] g = '0;
    for (int unsigned r = 0; r < D; r++) g[4*r +: 4] = mq[r];
    return g;
  endfunction

  task automatic model_edge(input bit e, input logic [3:0] c);
    bit         step;
    logic [4:0] d;
    logic [3:0] ent;
    step    = 0;
    m_pulse = 0;
    if (m_done) return;
    if (m_sched > 0) begin
      m_sched--;
      if (m_sched == 0) step = 1;
    end
    if (e) begin
      m_en_edges++;
      if (m_en_edges % TD == 0) m_sched = 2;
    end
    if (step) begin
      d = rom[m_ptr];
      if (m_ended || d[4]) ent = 4'b0000;
      else begin
        ent = d[3:0];
        m_ptr++;
      end
      if (d[4]) m_ended = 1;
      void'(mq.pop_front());
      mq.push_back(ent);
      m_pulse = 1;
      if (m_ended && model_empty()) m_done = 1;
    end else begin
      mq[0] = mq[0] & ~c;
    end
  endtask

  task automatic check_all();
    chk("gameclk", gameclk, m_pulse);
    chk("grid", grid, model_grid());
    chk("intersections", intersections, mq[0]);
    chk("done", done, m_done);
    chk("chart_addr", chart_addr, m_ptr);
  endtask

  task automatic tick(input bit e, input logic [3:0] c);
    @(negedge clock);
    enable = e;
    clear  = c;
    @(posedge clock);
    model_edge(e, c);
    #1;
    check_all();
  endtask

  task automatic wait_pulse(output int k, input int limit);
    k = 0;
    do begin
      tick(1'b1, 4'b0000);
      k++;
    end while (gameclk !== 1'b1 && k < limit);
    if (gameclk !== 1'b1) chk("pulse_timeout", gameclk, 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_grid"}, grid, 0);
    chk({tag, "_gameclk"}, gameclk, 0);
    chk({tag, "_intersections"}, intersections, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_chart_addr"}, chart_addr, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset  = 1'b0;
    enable = 1'($urandom);
    clear  = 4'($urandom);
    #2;
    check_zero("rst_async");
    repeat (4) begin
      @(negedge clock);
      enable = 1'($urandom);
      clear  = 4'($urandom);
    end
    #2;
    check_zero("rst_hold");
    model_reset();
    @(negedge clock);
    reset  = 1'b1;
    enable = 1'b0;
    clear  = 4'b0000;
  endtask

  task automatic load_directed_chart();
    for (int i = 0; i < (1<<AW); i++) rom[i] = 5'b10000;
    rom[0] = 5'b00001;
    rom[1] = 5'b00010;
    rom[2] = 5'b10000;
  endtask

  initial begin
    int k;
    int extra;
    int guard;

    reset  = 1'b0;
    enable = 1'b0;
    clear  = 4'b0000;
    model_reset();

    // Scroll and end of chart
    load_directed_chart();
    do_reset();
    wait_pulse(k, 50);
    chk("first_pulse_latency", k, TD + 2);
    chk("entry_row_first", grid[15:12], 4'b0001);
    for (int p = 2; p <= 6; p++) begin
      wait_pulse(k, 50);
      chk("pulse_spacing", k, TD);
      if (p == 4) chk("step4_intersections", intersections, 4'b0001);
      if (p == 5) chk("step5_intersections", intersections, 4'b0010);
      if (p == 6) begin
        chk("step6_intersections", intersections, 4'b0000);
        chk("step6_done", done, 1);
        chk("step6_grid", grid, 0);
        chk("end_chart_addr", chart_addr, 2);
      end
    end
    extra = 0;
    repeat (20) begin
      tick(1'b1, 4'b0000);
      if (gameclk === 1'b1) extra++;
    end
    chk("pulses_after_done", extra, 0);
    chk("done_held", done, 1);

    // Clear outside and inside the LOAD cycle
    do_reset();
    repeat (4) wait_pulse(k, 50);
    tick(1'b1, 4'b0001);
    chk("clear_row0", intersections, 4'b0000);
    guard = 0;
    while (m_sched != 1 && guard < 20) begin
      tick(1'b1, 4'b0000);
      guard++;
    end
    tick(1'b1, 4'b1111);
    chk("clear_in_load_gameclk", gameclk, 1);
    chk("clear_in_load_row0", intersections, 4'b0010);

    // Pause mid-COUNT, then reset in a LOAD cycle
    do_reset();
    wait_pulse(k, 50);
    repeat (10) tick(1'b0, 4'b0000);
    wait_pulse(k, 50);
    chk("resume_latency", k, 4);
    guard = 0;
    while (m_sched != 1 && guard < 20) begin
      tick(1'b1, 4'b0000);
      guard++;
    end
    #2;
    reset = 1'b0;
    #1;
    check_zero("rst_in_load");
    do_reset();

    // Randomized charts, pauses and clears
    for (int it = 0; it < 3; it++) begin
      int n;
      int post;
      n = $urandom_range(4, 12);
      for (int i = 0; i < (1<<AW); i++) rom[i] = 5'b10000;
      for (int i = 0; i < n; i++) rom[i] = {1'b0, 4'($urandom)};
      do_reset();
      post  = 0;
      guard = 0;
      while (post < 10 && guard < 1500) begin
        tick($urandom_range(0, 9) < 8,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000);
        if (m_done) post++;
        guard++;
      end
      chk("rand_done", done, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
